// File: rtl/coffee_dispense_seq.sv
// Brewing sequencer: accepts one drink order per handshake and steps the
// grinder, pump, milk and foam actuators for fixed cycle counts, halting on faults.
module coffee_dispense_seq #(
    parameter int GRIND_CYC = 8,
    parameter int BREW_CYC  = 16,
    parameter int MILK_CYC  = 12,
    parameter int FOAM_CYC  = 6,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_drink,
    output logic       req_ready,
    input  logic       cup_present,
    input  logic       water_ok,
    input  logic       clear_err,
    output logic       grinder_en,
    output logic       pump_en,
    output logic       milk_en,
    output logic       foam_en,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] current_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_GRIND = 3'b001,
        S_BREW  = 3'b010,
        S_MILK  = 3'b011,
        S_FOAM  = 3'b100,
        S_DONE  = 3'b101,
        S_FAULT = 3'b110
    } state_t;

    localparam logic [1:0] ESPRESSO   = 2'b01;
    localparam logic [1:0] CAPPUCCINO = 2'b11;

    localparam logic [CNT_W-1:0] GRIND_LD = CNT_W'(GRIND_CYC - 1);
    localparam logic [CNT_W-1:0] BREW_LD  = CNT_W'(BREW_CYC - 1);
    localparam logic [CNT_W-1:0] MILK_LD  = CNT_W'(MILK_CYC - 1);
    localparam logic [CNT_W-1:0] FOAM_LD  = CNT_W'(FOAM_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       drink_q, drink_d;
    logic             active;
    logic             fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drink_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drink_q <= drink_d;
        end
    end

    assign active = (state_q == S_GRIND) || (state_q == S_BREW) ||
                    (state_q == S_MILK)  || (state_q == S_FOAM);
    // Water level only matters while the pump runs; a missing cup aborts any step.
    assign fault  = active && (!cup_present || ((state_q == S_BREW) && !water_ok));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drink_d = drink_q;
        if (fault) begin
            state_d = S_FAULT;
            cnt_d   = '0;
            drink_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready && (req_drink != 2'b00)) begin
                        state_d = S_GRIND;
                        cnt_d   = GRIND_LD;
                        drink_d = req_drink;
                    end
                end
                S_GRIND: begin
                    if (cnt_q == '0) begin
                        state_d = S_BREW;
                        cnt_d   = BREW_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_BREW: begin
                    if (cnt_q == '0) begin
                        if (drink_q == ESPRESSO) begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_MILK;
                            cnt_d   = MILK_LD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_MILK: begin
                    if (cnt_q == '0) begin
                        if (drink_q == CAPPUCCINO) begin
                            state_d = S_FOAM;
                            cnt_d   = FOAM_LD;
                        end else begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_FOAM: begin
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    drink_d = '0;
                end
                S_FAULT: begin
                    if (clear_err && cup_present) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    drink_d = '0;
                end
            endcase
        end
    end

    assign req_ready     = (state_q == S_IDLE) && cup_present && water_ok;
    assign grinder_en    = (state_q == S_GRIND);
    assign pump_en       = (state_q == S_BREW);
    assign milk_en       = (state_q == S_MILK);
    assign foam_en       = (state_q == S_FOAM);
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_FAULT);
    assign busy          = (state_q != S_IDLE);
    assign current_state = state_q;

endmodule

// File: tb/tb_coffee_dispense_seq.sv
// Directed bench for coffee_dispense_seq at default parameters; expected
// step lengths and done positions are hand-computed from 8/16/12/6 cycles.
module tb_coffee_dispense_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_drink;
    logic       req_ready;
    logic       cup_present;
    logic       water_ok;
    logic       clear_err;
    logic       grinder_en, pump_en, milk_en, foam_en;
    logic       busy, done, error;
    logic [2:0] current_state;

    int n_cmp = 0;
    int n_bad = 0;

    coffee_dispense_seq #(
        .GRIND_CYC(8), .BREW_CYC(16), .MILK_CYC(12), .FOAM_CYC(6), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_drink(req_drink),
        .req_ready(req_ready), .cup_present(cup_present), .water_ok(water_ok),
        .clear_err(clear_err), .grinder_en(grinder_en), .pump_en(pump_en),
        .milk_en(milk_en), .foam_en(foam_en), .busy(busy), .done(done),
        .error(error), .current_state(current_state)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Present an order for exactly one edge; returns at cycle 1 after that edge.
    task automatic accept(input logic [1:0] drink);
        req_valid = 1'b1;
        req_drink = drink;
        cyc();
        req_valid = 1'b0;
    endtask

    // Measures enable widths and done position, starting at cycle 1 after accept.
    task automatic observe(input int max, output int g, output int p, output int m,
                           output int f, output int done_at, output int overlap);
        g = 0; p = 0; m = 0; f = 0; done_at = -1; overlap = 0;
        for (int i = 1; i <= max; i++) begin
            g += int'(grinder_en);
            p += int'(pump_en);
            m += int'(milk_en);
            f += int'(foam_en);
            if ((int'(grinder_en) + int'(pump_en) + int'(milk_en) + int'(foam_en)) > 1)
                overlap++;
            if (done) begin
                done_at = i;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_drink = 2'b00;
        cup_present = 1'b1; water_ok = 1'b1; clear_err = 1'b0;
        cycn(2);
        n_cmp++; if (current_state !== 3'b000) begin n_bad++; $display("FAIL reset_state: got %b want 000", current_state); end
        n_cmp++; if ({grinder_en, pump_en, milk_en, foam_en, busy, done, error} !== 7'b0) begin n_bad++;
            $display("FAIL reset_outputs: got %b want 0000000", {grinder_en, pump_en, milk_en, foam_en, busy, done, error}); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        water_ok = 1'b0; #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_water: got %b want 0", req_ready); end
        water_ok = 1'b1;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_espresso();
        int g, p, m, f, d, ov;
        accept(2'b01);
        req_drink = 2'b11;  // must not affect the registered order
        observe(60, g, p, m, f, d, ov);
        n_cmp++; if (g !== 8)  begin n_bad++; $display("FAIL esp_grind: got %0d want 8", g); end
        n_cmp++; if (p !== 16) begin n_bad++; $display("FAIL esp_pump: got %0d want 16", p); end
        n_cmp++; if (m !== 0)  begin n_bad++; $display("FAIL esp_milk: got %0d want 0", m); end
        n_cmp++; if (d !== 25) begin n_bad++; $display("FAIL esp_done_at: got %0d want 25", d); end
        cyc();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL esp_done_width: got %b want 0", done); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL esp_ready_after: got %b want 1", req_ready); end
    endtask

    task automatic test_cappuccino();
        int g, p, m, f, d, ov;
        accept(2'b11);
        observe(80, g, p, m, f, d, ov);
        n_cmp++; if ({g, p, m, f} !== {32'd8, 32'd16, 32'd12, 32'd6}) begin n_bad++;
            $display("FAIL cap_steps: got %0d/%0d/%0d/%0d want 8/16/12/6", g, p, m, f); end
        n_cmp++; if (ov !== 0)  begin n_bad++; $display("FAIL cap_overlap: got %0d want 0", ov); end
        n_cmp++; if (d !== 43) begin n_bad++; $display("FAIL cap_done_at: got %0d want 43", d); end
        cyc();
    endtask

    task automatic test_latte();
        int g, p, m, f, d, ov;
        accept(2'b10);
        observe(80, g, p, m, f, d, ov);
        n_cmp++; if (m !== 12) begin n_bad++; $display("FAIL latte_milk: got %0d want 12", m); end
        n_cmp++; if (f !== 0)  begin n_bad++; $display("FAIL latte_foam: got %0d want 0", f); end
        n_cmp++; if (d !== 37) begin n_bad++; $display("FAIL latte_done_at: got %0d want 37", d); end
        cyc();
    endtask

    task automatic test_fault_cup();
        accept(2'b10);
        cycn(12);  // cycle 13 = BREW cycle 5
        n_cmp++; if (pump_en !== 1'b1) begin n_bad++; $display("FAIL fc_in_brew: got %b want 1", pump_en); end
        cup_present = 1'b0;
        cyc();
        n_cmp++; if ({pump_en, error, current_state} !== 5'b0_1_110) begin n_bad++;
            $display("FAIL fc_fault: got pump=%b err=%b st=%b want 0 1 110", pump_en, error, current_state); end
        clear_err = 1'b1;
        cyc();
        n_cmp++; if (current_state !== 3'b110) begin n_bad++; $display("FAIL fc_clear_nocup: got %b want 110", current_state); end
        cup_present = 1'b1;
        cyc();
        clear_err = 1'b0;
        n_cmp++; if ({current_state, error, req_ready} !== 5'b000_0_1) begin n_bad++;
            $display("FAIL fc_recover: got st=%b err=%b rdy=%b want 000 0 1", current_state, error, req_ready); end
    endtask

    task automatic test_water();
        water_ok = 1'b0; req_valid = 1'b1; req_drink = 2'b01; #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL w_ready_low: got %b want 0", req_ready); end
        cyc();
        n_cmp++; if (current_state !== 3'b000) begin n_bad++; $display("FAIL w_no_accept: got %b want 000", current_state); end
        water_ok = 1'b1;
        cyc();
        req_valid = 1'b0;
        n_cmp++; if (current_state !== 3'b001) begin n_bad++; $display("FAIL w_accept: got %b want 001", current_state); end
        water_ok = 1'b0;
        cycn(7);  // cycle 8, last GRIND cycle
        n_cmp++; if ({current_state, error} !== 4'b001_0) begin n_bad++;
            $display("FAIL w_grind_nofault: got st=%b err=%b want 001 0", current_state, error); end
        cyc();
        n_cmp++; if (current_state !== 3'b010) begin n_bad++; $display("FAIL w_brew_entry: got %b want 010", current_state); end
        cyc();
        n_cmp++; if (current_state !== 3'b110) begin n_bad++; $display("FAIL w_brew_fault: got %b want 110", current_state); end
        water_ok = 1'b1; clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        n_cmp++; if (current_state !== 3'b000) begin n_bad++; $display("FAIL w_recover: got %b want 000", current_state); end
    endtask

    task automatic test_back_to_back();
        int acc = 0, dn = 0, idle_gap = 0;
        logic prev_g = 1'b0;
        req_valid = 1'b1; req_drink = 2'b01;
        for (int i = 1; i <= 78; i++) begin
            cyc();
            if (grinder_en && !prev_g) acc++;
            if (done) dn++;
            if (i == 26 && current_state == 3'b000) idle_gap = 1;
            prev_g = grinder_en;
        end
        req_valid = 1'b0;
        n_cmp++; if (acc !== 3) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
        n_cmp++; if (dn !== 3)  begin n_bad++; $display("FAIL b2b_dones: got %0d want 3", dn); end
        n_cmp++; if (idle_gap !== 1) begin n_bad++; $display("FAIL b2b_idle_gap: got %0d want 1", idle_gap); end
        n_cmp++; if (current_state !== 3'b000) begin n_bad++; $display("FAIL b2b_end_idle: got %b want 000", current_state); end
        // No-op order: handshake completes, sequencer stays idle.
        req_valid = 1'b1; req_drink = 2'b00; #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL noop_ready: got %b want 1", req_ready); end
        cyc();
        req_valid = 1'b0;
        cycn(2);
        n_cmp++; if ({busy, done, grinder_en} !== 3'b000) begin n_bad++;
            $display("FAIL noop_idle: got busy=%b done=%b grind=%b want 0 0 0", busy, done, grinder_en); end
    endtask

    task automatic test_reset_mid();
        int g, p, m, f, d, ov, dn = 0;
        accept(2'b11);
        cycn(29);  // cycle 30, inside MILK
        n_cmp++; if (milk_en !== 1'b1) begin n_bad++; $display("FAIL rm_in_milk: got %b want 1", milk_en); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({grinder_en, pump_en, milk_en, foam_en, current_state} !== 7'b0) begin n_bad++;
            $display("FAIL rm_async: got en=%b st=%b want 0000 000", {grinder_en, pump_en, milk_en, foam_en}, current_state); end
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (done) dn++;
        end
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL rm_no_done: got %0d want 0", dn); end
        accept(2'b01);
        observe(60, g, p, m, f, d, ov);
        n_cmp++; if (d !== 25) begin n_bad++; $display("FAIL rm_reorder_done: got %0d want 25", d); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_espresso();
        test_cappuccino();
        test_latte();
        test_fault_cup();
        test_water();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coffee_dispense_seq.md
Name: coffee_dispense_seq

Overview:
- Sequencer for the brewing datapath, downstream of the credit/selection FSM.
- Accepts one drink order per valid/ready handshake and drives the grinder, pump, milk and foam actuators for parameterised cycle counts.
- Reports busy/done/error back to the front panel.
- Halts all actuators safely on a cup-missing or water-low fault.

Parameters:
GRIND_CYC, 8, grinder-on duration in clk cycles (>=1)
BREW_CYC, 16, pump-on duration in clk cycles (>=1)
MILK_CYC, 12, milk-valve duration in clk cycles (>=1)
FOAM_CYC, 6, frother duration in clk cycles (>=1)
CNT_W, 8, step counter width; every *_CYC must be <= 2^CNT_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  1  order present
req_drink  input  2  01 espresso, 10 latte, 11 cappuccino, 00 no-op
req_ready  output  1  sequencer can accept an order
cup_present  input  1  cup sensor, level
water_ok  input  1  water-level sensor, level
clear_err  input  1  fault acknowledge, sampled level
grinder_en  output  1  grinder actuator
pump_en  output  1  brew pump actuator
milk_en  output  1  milk valve actuator
foam_en  output  1  frother actuator
busy  output  1  sequencer not in IDLE
done  output  1  one-cycle completion pulse
error  output  1  fault latched
current_state  output  3  state register, debug

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, drink register=00. All outputs 0 except req_ready, which follows its combinational equation.
- State encodings: IDLE 000, GRIND 001, BREW 010, MILK 011, FOAM 100, DONE 101, FAULT 110. Code 111 is unused and returns to IDLE next cycle.
- Outputs are Moore-decoded from the state register:
  - grinder_en=GRIND, pump_en=BREW, milk_en=MILK, foam_en=FOAM.
  - done=DONE, error=FAULT, busy = state!=IDLE.
- req_ready = (state==IDLE) & cup_present & water_ok.
- Accept: req_valid & req_ready at a rising edge.
  - Nonzero req_drink is registered and the FSM enters GRIND.
  - req_drink=00 completes the handshake; the FSM stays in IDLE with no outputs.
- Step timing:
  - On entry to each active step, the counter loads *_CYC-1. It decrements every cycle.
  - The step exits when counter==0, so each enable is high for exactly *_CYC cycles.
- Sequences:
  - espresso: GRIND→BREW→DONE.
  - latte: GRIND→BREW→MILK→DONE.
  - cappuccino: GRIND→BREW→MILK→FOAM→DONE.
- DONE lasts exactly 1 cycle, then IDLE. A new order is accepted no earlier than the cycle after DONE.
- Latency: if accepted at edge T, the first GRIND cycle follows T. Espresso DONE is the (GRIND_CYC+BREW_CYC+1)th cycle after T.
- Fault conditions, evaluated every cycle in GRIND/BREW/MILK/FOAM:
  - cup_present==0 in any active step.
  - water_ok==0 in BREW.
  - On a fault, the next state is FAULT. Actuators drop at that edge, and the counter and drink register clear.
  - Fault has priority over a simultaneous step completion.
- FAULT exits to IDLE when clear_err==1 & cup_present==1. Otherwise it stays in FAULT; clear_err is ignored in all other states.
- req_valid outside IDLE is ignored (req_ready=0). No queueing.
- req_drink changes after accept have no effect.
- Reset mid-operation aborts the drink immediately, with no done pulse.

Test Plan:
- Defaults, cup=1, water=1, espresso accepted at edge T → grinder_en high 8 cycles, then pump_en 16 cycles, done high for 1 cycle at cycle 25 after T; req_ready returns to 1 the next cycle.
- Cappuccino → grinder 8, pump 16, milk 12, foam 6 cycles, never two enables high together; done at cycle 43; latte → done at cycle 37 with foam_en never asserted.
- Latte with cup_present dropped at BREW cycle 5 → pump_en low at next edge, error=1, state 110; clear_err with cup=0 → stays FAULT; cup=1 & clear_err → IDLE, error=0, req_ready=1.
- water_ok=0 in IDLE with req_valid=1 → req_ready=0, no acceptance. water_ok=0 during GRIND → no fault. water_ok=0 at BREW cycle 1 → FAULT.
- req_valid held high with espresso during a busy sequence → exactly one accept per completed drink. req_drink=00 → handshake completes, busy stays 0.
- rst pulse mid-MILK, asynchronous to clk → all enables 0 and state 000 before the next edge, no done pulse. Order after reset release is accepted normally.
